// File: rtl/mvb_tx_scheduler_if.sv
// MVB transmit scheduler bus: request/ack pairs from the master-frame (poll
// table) and slave-frame (port response) sources, plus the frame encoder
// control port.
//   master modport : request sources / encoder side (drives requests,
//                    decode_over, frame_over; observes acks and encoder controls)
//   slave modport  : scheduler side (consumes requests, drives acks, send_frame,
//                    data_length, frame type flags and status pulses)
interface mvb_tx_scheduler_if;
    localparam int unsigned LEN_W = 7;

    logic             m_req;
    logic [LEN_W-1:0] m_len;
    logic             m_ack;
    logic             s_req;
    logic [LEN_W-1:0] s_len;
    logic             s_ack;
    logic             decode_over;
    logic             frame_over;
    logic             send_frame;
    logic [LEN_W-1:0] data_length;
    logic             master_frame;
    logic             slave_frame;
    logic             tx_busy;
    logic             tx_done;
    logic             tx_err;

    modport master (
        output m_req, m_len, s_req, s_len, decode_over, frame_over,
        input  m_ack, s_ack, send_frame, data_length, master_frame, slave_frame,
               tx_busy, tx_done, tx_err
    );

    modport slave (
        input  m_req, m_len, s_req, s_len, decode_over, frame_over,
        output m_ack, s_ack, send_frame, data_length, master_frame, slave_frame,
               tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/mvb_tx_scheduler.sv
// MVB transmit scheduler: arbitrates master/slave frame requests (slave has
// priority), drives the encoder start strobe for one frame at a time, waits for
// frame completion or timeout, then enforces an inter-frame gap.
//   clk_6M : 6 MHz clock, rising edge
//   rst    : synchronous, active-low reset
//   bus    : mvb_tx_scheduler_if.slave (requests, acks, encoder control, status)
// All outputs are registered; each output value is computed on the transition
// into the state it belongs to, so the ack is visible in the ARB cycle and
// send_frame rises in the first STROBE cycle.
module mvb_tx_scheduler #(
    parameter int unsigned SEND_HI = 4,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 2047,
    parameter int unsigned IFG     = 12
) (
    input logic              clk_6M,
    input logic              rst,
    mvb_tx_scheduler_if.slave bus
);
    localparam int unsigned LEN_W = 7;
    localparam int unsigned HI_W  = 3;
    localparam int unsigned TO_W  = 11;
    localparam int unsigned GAP_W = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_STROBE  = 3'd2,
        S_RELEASE = 3'd3,
        S_BUSY    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [HI_W-1:0]    hi_cnt_q, hi_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               send_frame_q, send_frame_d;
    logic [LEN_W-1:0]   data_length_q, data_length_d;
    logic               master_frame_q, master_frame_d;
    logic               slave_frame_q, slave_frame_d;
    logic               tx_busy_q, tx_busy_d;
    logic               tx_done_q, tx_done_d;
    logic               tx_err_q, tx_err_d;
    logic               m_ack_q, m_ack_d;
    logic               s_ack_q, s_ack_d;

    // Shared decode terms for the next-state and output processes
    logic go_c, len_bad_c, hi_last_c, to_hit_c, gap_last_c;

    assign go_c       = (bus.s_req | bus.m_req) & ~bus.decode_over;
    assign len_bad_c  = (data_length_q == '0) || (data_length_q > LEN_W'(MAX_LEN));
    assign hi_last_c  = (hi_cnt_q == HI_W'(SEND_HI - 1));
    // BUSY may last TIMEOUT cycles; the error fires as the counter reaches TIMEOUT
    assign to_hit_c   = (to_cnt_q >= TO_W'(TIMEOUT - 1));
    assign gap_last_c = (gap_cnt_q == GAP_W'(IFG - 1));

    // State and output registers
    always_ff @(posedge clk_6M) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            hi_cnt_q       <= '0;
            to_cnt_q       <= '0;
            gap_cnt_q      <= '0;
            send_frame_q   <= 1'b0;
            data_length_q  <= '0;
            master_frame_q <= 1'b0;
            slave_frame_q  <= 1'b0;
            tx_busy_q      <= 1'b0;
            tx_done_q      <= 1'b0;
            tx_err_q       <= 1'b0;
            m_ack_q        <= 1'b0;
            s_ack_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_cnt_q       <= hi_cnt_d;
            to_cnt_q       <= to_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            send_frame_q   <= send_frame_d;
            data_length_q  <= data_length_d;
            master_frame_q <= master_frame_d;
            slave_frame_q  <= slave_frame_d;
            tx_busy_q      <= tx_busy_d;
            tx_done_q      <= tx_done_d;
            tx_err_q       <= tx_err_d;
            m_ack_q        <= m_ack_d;
            s_ack_q        <= s_ack_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (go_c) state_d = S_ARB;
            S_ARB:     state_d = len_bad_c ? S_IDLE : S_STROBE;
            S_STROBE:  if (hi_last_c) state_d = S_RELEASE;
            S_RELEASE: state_d = S_BUSY;
            S_BUSY:    if (bus.frame_over || to_hit_c) state_d = S_GAP;
            S_GAP:     if (gap_last_c) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and counter logic
    always_comb begin
        send_frame_d   = send_frame_q;
        data_length_d  = data_length_q;
        master_frame_d = master_frame_q;
        slave_frame_d  = slave_frame_q;
        tx_busy_d      = tx_busy_q;
        to_cnt_d       = to_cnt_q;
        hi_cnt_d       = '0;
        gap_cnt_d      = '0;
        tx_done_d      = 1'b0;
        tx_err_d       = 1'b0;
        m_ack_d        = 1'b0;
        s_ack_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Grant is registered on entry to ARB; slave wins a tie
                if (go_c) begin
                    if (bus.s_req) begin
                        s_ack_d        = 1'b1;
                        slave_frame_d  = 1'b1;
                        master_frame_d = 1'b0;
                        data_length_d  = bus.s_len;
                    end else begin
                        m_ack_d        = 1'b1;
                        master_frame_d = 1'b1;
                        slave_frame_d  = 1'b0;
                        data_length_d  = bus.m_len;
                    end
                end
            end
            S_ARB: begin
                if (len_bad_c) begin
                    tx_err_d       = 1'b1;
                    master_frame_d = 1'b0;
                    slave_frame_d  = 1'b0;
                end else begin
                    send_frame_d = 1'b1;
                    tx_busy_d    = 1'b1;
                end
            end
            S_STROBE: begin
                if (hi_last_c) send_frame_d = 1'b0;
                else           hi_cnt_d     = hi_cnt_q + HI_W'(1);
            end
            S_RELEASE: begin
                to_cnt_d = '0;
            end
            S_BUSY: begin
                if (to_cnt_q != TO_W'(TIMEOUT)) to_cnt_d = to_cnt_q + TO_W'(1);
                // Completion wins over a coincident timeout
                if (bus.frame_over)  tx_done_d = 1'b1;
                else if (to_hit_c)   tx_err_d  = 1'b1;
            end
            S_GAP: begin
                if (gap_last_c) begin
                    master_frame_d = 1'b0;
                    slave_frame_d  = 1'b0;
                    data_length_d  = '0;
                    tx_busy_d      = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                send_frame_d = 1'b0;
            end
        endcase
    end

    assign bus.send_frame   = send_frame_q;
    assign bus.data_length  = data_length_q;
    assign bus.master_frame = master_frame_q;
    assign bus.slave_frame  = slave_frame_q;
    assign bus.tx_busy      = tx_busy_q;
    assign bus.tx_done      = tx_done_q;
    assign bus.tx_err       = tx_err_q;
    assign bus.m_ack        = m_ack_q;
    assign bus.s_ack        = s_ack_q;
endmodule
